// File: rtl/baseball_pkg.sv
// Shared constants, event encoding and LED helper for the parametrised baseball scoreboard.
package baseball_pkg;

  localparam logic [1:0] HIT_SINGLE = 2'd0;
  localparam logic [1:0] HIT_DOUBLE = 2'd1;
  localparam logic [1:0] HIT_TRIPLE = 2'd2;
  localparam logic [1:0] HIT_HR     = 2'd3;

  localparam logic HALF_TOP    = 1'b0;
  localparam logic HALF_BOTTOM = 1'b1;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_OUT,
    EV_HIT,
    EV_STRIKE,
    EV_FOUL,
    EV_BALL
  } event_e;

  localparam int THERM_W = 32;

  // Count n lights the n lowest LEDs; callers truncate to their LED width.
  function automatic logic [THERM_W-1:0] therm_from_count(input int unsigned count);
    if (count >= THERM_W) return '1;
    return (THERM_W'(1) << count) - THERM_W'(1);
  endfunction

endpackage

// File: rtl/bb_btn_pulse.sv
// Button conditioner: 2-flop synchroniser on an active-low button, then a 1-cycle press pulse.
module bb_btn_pulse (
  input  logic iCLK,
  input  logic iRSTn,
  input  logic i_btn_n,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic       r_prev;

  // Flops reset to the released (high) level so reset itself never looks like a press.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_btn_n};
      r_prev <= r_sync[1];
    end
  end

  assign o_pulse = r_prev & ~r_sync[1];

endmodule

// File: rtl/baseball_scoreboard_p.sv
// Baseball scoreboard: count, bases, runs, innings and game-over detection.
// Optional foul button enabled by defining SCOREBOARD_FOUL_EN.
module baseball_scoreboard_p
  import baseball_pkg::*;
#(
  parameter int STRIKES_MAX = 3,
  parameter int BALLS_MAX   = 4,
  parameter int OUTS_MAX    = 3,
  parameter int NUM_BASES   = 3,
  parameter int RUN_W       = 5,
  parameter int INN_W       = 4,
  parameter int INNINGS_REG = 9
) (
  input  logic                   iCLK,
  input  logic                   iRSTn,
  input  logic                   iSTRIKE,
  input  logic                   iBALL,
  input  logic                   iHIT,
  input  logic [1:0]             iHIT_TYPE,
  input  logic                   iHIT_OUT,
`ifdef SCOREBOARD_FOUL_EN
  input  logic                   iFOUL,
`endif
  output logic [STRIKES_MAX-2:0] oSTRIKE_LED,
  output logic [BALLS_MAX-2:0]   oBALL_LED,
  output logic [OUTS_MAX-2:0]    oOUT_LED,
  output logic [NUM_BASES-1:0]   oBASE,
  output logic [RUN_W-1:0]       oSCORE_AWAY,
  output logic [RUN_W-1:0]       oSCORE_HOME,
  output logic [INN_W-1:0]       oINNING,
  output logic                   oHALF,
  output logic                   oGAME_OVER
);

  localparam int S_W = $clog2(STRIKES_MAX);
  localparam int B_W = $clog2(BALLS_MAX);
  localparam int O_W = $clog2(OUTS_MAX);
  localparam int V_W = NUM_BASES + 5;

  logic [S_W-1:0]       r_strikes, w_strikes_n;
  logic [B_W-1:0]       r_balls, w_balls_n;
  logic [O_W-1:0]       r_outs, w_outs_n;
  logic [NUM_BASES-1:0] r_bases, w_bases_n;
  logic [RUN_W-1:0]     r_away, w_away_n, r_home, w_home_n;
  logic [INN_W-1:0]     r_inning, w_inning_n;
  logic                 r_half, w_half_n, r_over, w_over_n;

  logic w_p_strike, w_p_ball, w_p_hit, w_p_out;
  bb_btn_pulse u_strike (.iCLK(iCLK), .iRSTn(iRSTn), .i_btn_n(iSTRIKE),  .o_pulse(w_p_strike));
  bb_btn_pulse u_ball   (.iCLK(iCLK), .iRSTn(iRSTn), .i_btn_n(iBALL),    .o_pulse(w_p_ball));
  bb_btn_pulse u_hit    (.iCLK(iCLK), .iRSTn(iRSTn), .i_btn_n(iHIT),     .o_pulse(w_p_hit));
  bb_btn_pulse u_out    (.iCLK(iCLK), .iRSTn(iRSTn), .i_btn_n(iHIT_OUT), .o_pulse(w_p_out));
`ifdef SCOREBOARD_FOUL_EN
  logic w_p_foul;
  bb_btn_pulse u_foul   (.iCLK(iCLK), .iRSTn(iRSTn), .i_btn_n(iFOUL),    .o_pulse(w_p_foul));
`endif

  event_e w_ev;
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_ev = EV_NONE;
    if (!r_over) begin
      if (w_p_out)         w_ev = EV_OUT;
      else if (w_p_hit)    w_ev = EV_HIT;
      else if (w_p_strike) w_ev = EV_STRIKE;
`ifdef SCOREBOARD_FOUL_EN
      else if (w_p_foul)   w_ev = EV_FOUL;
`endif
      else if (w_p_ball)   w_ev = EV_BALL;
    end
  end

  logic [2:0]       w_shift, w_runs;
  logic [V_W-1:0]   w_hit_vec;
  logic             w_carry, w_take_out;
  logic [RUN_W+2:0] w_sum;
  logic [RUN_W-1:0] w_scored;

  always_comb begin
    w_strikes_n = r_strikes;
    w_balls_n   = r_balls;
    w_outs_n    = r_outs;
    w_bases_n   = r_bases;
    w_away_n    = r_away;
    w_home_n    = r_home;
    w_inning_n  = r_inning;
    w_half_n    = r_half;
    w_over_n    = r_over;
    w_runs      = '0;
    w_take_out  = 1'b0;
    w_carry     = 1'b1;
    w_sum       = '0;
    w_scored    = '0;

    case (iHIT_TYPE)
      HIT_SINGLE: w_shift = 3'd1;
      HIT_DOUBLE: w_shift = 3'd2;
      HIT_TRIPLE: w_shift = 3'd3;
      HIT_HR:     w_shift = 3'd4;
      default:    w_shift = 3'd1;
    endcase
    // Bit 0 is the batter at home; bits above NUM_BASES are runners who crossed the plate.
    w_hit_vec = {4'b0, r_bases, 1'b1} << w_shift;

    case (w_ev)
      EV_OUT: begin
        w_strikes_n = '0;
        w_balls_n   = '0;
        w_take_out  = 1'b1;
      end
      EV_HIT: begin
        w_strikes_n = '0;
        w_balls_n   = '0;
        w_bases_n   = w_hit_vec[NUM_BASES:1];
        w_runs      = 3'($countones(w_hit_vec[V_W-1:NUM_BASES+1]));
      end
      EV_STRIKE: begin
        if (int'(r_strikes) < STRIKES_MAX - 1) begin
          w_strikes_n = r_strikes + 1'b1;
        end else begin
          w_strikes_n = '0;
          w_balls_n   = '0;
          w_take_out  = 1'b1;
        end
      end
`ifdef SCOREBOARD_FOUL_EN
      EV_FOUL: begin
        if (int'(r_strikes) < STRIKES_MAX - 1) w_strikes_n = r_strikes + 1'b1;
      end
`endif
      EV_BALL: begin
        if (int'(r_balls) < BALLS_MAX - 1) begin
          w_balls_n = r_balls + 1'b1;
        end else begin
          w_strikes_n = '0;
          w_balls_n   = '0;
          // A runner is forced only while every base behind him is occupied.
          for (int i = 0; i < NUM_BASES; i++) begin
            w_bases_n[i] = r_bases[i] | w_carry;
            w_carry      = w_carry & r_bases[i];
          end
          w_runs = {2'b00, w_carry};
        end
      end
      default: ;
    endcase

    w_sum    = (RUN_W+3)'(r_half == HALF_TOP ? r_away : r_home) + (RUN_W+3)'(w_runs);
    w_scored = (w_sum[RUN_W+2:RUN_W] != 3'b000) ? '1 : w_sum[RUN_W-1:0];
    if (r_half == HALF_TOP) w_away_n = w_scored;
    else                    w_home_n = w_scored;

    if (r_half == HALF_BOTTOM && int'(r_inning) >= INNINGS_REG &&
        w_runs != 3'd0 && w_home_n > w_away_n)
      w_over_n = 1'b1;

    if (w_take_out) begin
      if (int'(r_outs) + 1 < OUTS_MAX) begin
        w_outs_n = r_outs + 1'b1;
      end else begin
        w_outs_n    = '0;
        w_bases_n   = '0;
        w_strikes_n = '0;
        w_balls_n   = '0;
        w_half_n    = ~r_half;
        if (int'(r_inning) >= INNINGS_REG &&
            ((r_half == HALF_TOP) ? (r_home > r_away) : (r_home != r_away)))
          w_over_n = 1'b1;
        if (r_half == HALF_BOTTOM) begin
          if (&r_inning) w_over_n   = 1'b1;
          else           w_inning_n = r_inning + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_strikes <= '0;
      r_balls   <= '0;
      r_outs    <= '0;
      r_bases   <= '0;
      r_away    <= '0;
      r_home    <= '0;
      r_inning  <= INN_W'(1);
      r_half    <= HALF_TOP;
      r_over    <= 1'b0;
    end else begin
      r_strikes <= w_strikes_n;
      r_balls   <= w_balls_n;
      r_outs    <= w_outs_n;
      r_bases   <= w_bases_n;
      r_away    <= w_away_n;
      r_home    <= w_home_n;
      r_inning  <= w_inning_n;
      r_half    <= w_half_n;
      r_over    <= w_over_n;
    end
  end

  assign oSTRIKE_LED = (STRIKES_MAX-1)'(therm_from_count(int'(r_strikes)));
  assign oBALL_LED   = (BALLS_MAX-1)'(therm_from_count(int'(r_balls)));
  assign oOUT_LED    = (OUTS_MAX-1)'(therm_from_count(int'(r_outs)));
  assign oBASE       = r_bases;
  assign oSCORE_AWAY = r_away;
  assign oSCORE_HOME = r_home;
  assign oINNING     = r_inning;
  assign oHALF       = r_half;
  assign oGAME_OVER  = r_over;

endmodule

// File: tb/tb_baseball_scoreboard_p.sv
// Directed bench for baseball_scoreboard_p with default parameters (foul feature off).
module tb_baseball_scoreboard_p;

  logic       iCLK = 1'b0;
  logic       iRSTn = 1'b0;
  logic       iSTRIKE = 1'b1, iBALL = 1'b1, iHIT = 1'b1, iHIT_OUT = 1'b1;
  logic [1:0] iHIT_TYPE = 2'd0;
  logic [1:0] oSTRIKE_LED, oOUT_LED;
  logic [2:0] oBALL_LED, oBASE;
  logic [4:0] oSCORE_AWAY, oSCORE_HOME;
  logic [3:0] oINNING;
  logic       oHALF, oGAME_OVER;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] B_BALL = 4'b0001, B_STRIKE = 4'b0010, B_HIT = 4'b0100, B_OUT = 4'b1000;

  baseball_scoreboard_p dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iSTRIKE(iSTRIKE), .iBALL(iBALL), .iHIT(iHIT),
    .iHIT_TYPE(iHIT_TYPE), .iHIT_OUT(iHIT_OUT),
    .oSTRIKE_LED(oSTRIKE_LED), .oBALL_LED(oBALL_LED), .oOUT_LED(oOUT_LED), .oBASE(oBASE),
    .oSCORE_AWAY(oSCORE_AWAY), .oSCORE_HOME(oSCORE_HOME), .oINNING(oINNING),
    .oHALF(oHALF), .oGAME_OVER(oGAME_OVER)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] m, input logic [1:0] ht);
    iHIT_TYPE = ht;
    iBALL     = ~m[0];
    iSTRIKE   = ~m[1];
    iHIT      = ~m[2];
    iHIT_OUT  = ~m[3];
  endtask

  // Hold the buttons for 4 cycles, release, then let everything settle.
  task automatic press(input logic [3:0] m, input logic [1:0] ht);
    @(negedge iCLK);
    drive(m, ht);
    repeat (4) @(negedge iCLK);
    drive(4'b0000, ht);
    repeat (4) @(negedge iCLK);
  endtask

  initial begin
    repeat (3) @(negedge iCLK);
    check("rst_strike", oSTRIKE_LED, 0);
    check("rst_ball",   oBALL_LED,   0);
    check("rst_out",    oOUT_LED,    0);
    check("rst_base",   oBASE,       0);
    check("rst_away",   oSCORE_AWAY, 0);
    check("rst_home",   oSCORE_HOME, 0);
    check("rst_inning", oINNING,     1);
    check("rst_half",   oHALF,       0);
    check("rst_over",   oGAME_OVER,  0);
    iRSTn = 1'b1;
    repeat (2) @(negedge iCLK);

    // Press-to-LED latency is exactly three rising edges.
    drive(B_STRIKE, 2'd0);
    @(posedge iCLK); #1 check("lat_edge1", oSTRIKE_LED, 2'b00);
    @(posedge iCLK); #1 check("lat_edge2", oSTRIKE_LED, 2'b00);
    @(posedge iCLK); #1 check("lat_edge3", oSTRIKE_LED, 2'b01);
    repeat (2) @(negedge iCLK);
    drive(4'b0000, 2'd0);
    repeat (4) @(negedge iCLK);

    press(B_STRIKE, 2'd0);
    check("two_strikes", oSTRIKE_LED, 2'b11);
    press(B_STRIKE, 2'd0);
    check("k_strikes", oSTRIKE_LED, 2'b00);
    check("k_out",     oOUT_LED,    2'b01);

    // Three singles load the bases with no runs.
    repeat (3) press(B_HIT, 2'd0);
    check("load_base", oBASE, 3'b111);
    check("load_away", oSCORE_AWAY, 0);

    repeat (3) press(B_BALL, 2'd0);
    check("three_balls", oBALL_LED, 3'b111);
    press(B_BALL, 2'd0);
    check("walk_base",  oBASE,       3'b111);
    check("walk_away",  oSCORE_AWAY, 1);
    check("walk_balls", oBALL_LED,   3'b000);

    press(B_HIT, 2'd3);
    check("grand_slam_base", oBASE,       3'b000);
    check("grand_slam_away", oSCORE_AWAY, 5);
    press(B_HIT, 2'd2);
    check("triple_base", oBASE, 3'b100);
    // Walk with only third occupied: batter to first, third not forced.
    repeat (4) press(B_BALL, 2'd0);
    check("walk_unforced_base", oBASE,       3'b101);
    check("walk_unforced_away", oSCORE_AWAY, 5);
    // Double from first+third: {101,1} << 2 leaves second+third, third-base runner scores.
    press(B_HIT, 2'd1);
    check("double_base", oBASE,       3'b110);
    check("double_away", oSCORE_AWAY, 6);

    press(B_STRIKE | B_BALL, 2'd0);
    check("prio_sb_strike", oSTRIKE_LED, 2'b01);
    check("prio_sb_ball",   oBALL_LED,   3'b000);
    press(B_OUT | B_HIT, 2'd3);
    check("prio_oh_out",    oOUT_LED,    2'b11);
    check("prio_oh_base",   oBASE,       3'b110);
    check("prio_oh_strike", oSTRIKE_LED, 2'b00);
    check("prio_oh_away",   oSCORE_AWAY, 6);

    press(B_OUT, 2'd0);
    check("end_top1_half",   oHALF,    1);
    check("end_top1_inning", oINNING,  1);
    check("end_top1_out",    oOUT_LED, 2'b00);
    check("end_top1_base",   oBASE,    3'b000);

    // Home ties it at 6 with three two-run homers.
    repeat (3) begin
      press(B_HIT, 2'd0);
      press(B_HIT, 2'd3);
    end
    check("bot1_home", oSCORE_HOME, 6);
    check("bot1_away", oSCORE_AWAY, 6);
    repeat (3) press(B_OUT, 2'd0);
    check("end_bot1_half",   oHALF,   0);
    check("end_bot1_inning", oINNING, 2);

    repeat (45) press(B_OUT, 2'd0);
    check("bot9_inning", oINNING,    9);
    check("bot9_half",   oHALF,      1);
    check("bot9_over",   oGAME_OVER, 0);

    press(B_HIT, 2'd0);
    check("bot9_single", oBASE, 3'b001);
    drive(B_HIT, 2'd3);
    @(posedge iCLK); @(posedge iCLK); #1;
    check("walkoff_pre_home", oSCORE_HOME, 6);
    check("walkoff_pre_over", oGAME_OVER,  0);
    @(posedge iCLK); #1;
    check("walkoff_home", oSCORE_HOME, 8);
    check("walkoff_over", oGAME_OVER,  1);
    check("walkoff_base", oBASE,       3'b000);
    repeat (2) @(negedge iCLK);
    drive(4'b0000, 2'd0);
    repeat (4) @(negedge iCLK);

    press(B_STRIKE, 2'd0);
    press(B_BALL, 2'd0);
    press(B_HIT, 2'd0);
    check("frozen_strike", oSTRIKE_LED, 2'b00);
    check("frozen_ball",   oBALL_LED,   3'b000);
    check("frozen_base",   oBASE,       3'b000);
    check("frozen_home",   oSCORE_HOME, 8);
    check("frozen_over",   oGAME_OVER,  1);

    // Asynchronous reset between clock edges.
    @(negedge iCLK);
    #1 iRSTn = 1'b0;
    #1;
    check("async_inning", oINNING,     1);
    check("async_half",   oHALF,       0);
    check("async_over",   oGAME_OVER,  0);
    check("async_home",   oSCORE_HOME, 0);
    check("async_away",   oSCORE_AWAY, 0);
    @(negedge iCLK);
    iRSTn = 1'b1;
    repeat (2) @(negedge iCLK);
    press(B_STRIKE, 2'd0);
    check("post_rst_strike", oSTRIKE_LED, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
